pedge_generator: RTL and testbench

//  Transmit side of the positive-edge signalling scheme: converts one-cycle request pulses into clean

---
 rtl/pedge_gen_pkg.sv | 18 +
 rtl/pedge_gen_lane.sv | 122 ++++++++++++
 rtl/pedge_generator.sv | 80 ++++++++
 tb/tb_pedge_generator.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pedge_gen_pkg.sv
// Shared types and constants for the positive-edge generator.
// Lane FSM encoding, drop counter width, and a compile-time max helper
// used to size the per-lane phase timer.
package pedge_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } lane_state_t;

    localparam int DROP_CNT_W = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pedge_gen_lane.sv
// One lane of the positive-edge generator.
// Turns one-cycle requests into a HIGH_CYCLES-wide high pulse followed by
// at least LOW_CYCLES low cycles. Requests arriving while the lane is busy
// are queued in a saturating pending counter. A request that cannot be
// queued raises the sticky ovf bit and pulses the drop strobe (same cycle
// as the offending request).
module pedge_gen_lane
    import pedge_gen_pkg::*;
#(
    parameter int HIGH_CYCLES = 1,
    parameter int LOW_CYCLES  = 1,
    parameter int PEND_W      = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic ovf_clr,
    output logic out,
    output logic busy,
    output logic ovf,
    output logic drop
);

    // Timer counts down to zero within each phase; zero marks the final cycle.
    localparam int TW = $clog2(max_int(HIGH_CYCLES, LOW_CYCLES) + 1);

    localparam logic [TW-1:0]     H_LOAD   = TW'(HIGH_CYCLES - 1);
    localparam logic [TW-1:0]     L_LOAD   = TW'(LOW_CYCLES - 1);
    localparam logic [TW-1:0]     T_ONE    = TW'(1);
    localparam logic [PEND_W-1:0] P_ONE    = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    lane_state_t       state;
    lane_state_t       state_nxt;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     timer_nxt;
    logic [PEND_W-1:0] pending;
    logic [PEND_W-1:0] pending_nxt;
    logic              final_gap;
    logic              queue_req;

    // The last GAP cycle is the only busy cycle where a request launches
    // directly instead of being queued.
    assign final_gap = (state == GAP) && (timer == '0);
    assign queue_req = req && ((state == HIGH) || ((state == GAP) && !final_gap));

    assign busy = (state != IDLE) || (pending != '0);

    // Next-state, timer and pending-count decode.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        pending_nxt = pending;
        drop        = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = HIGH;
                    timer_nxt = H_LOAD;
                end
            end
            HIGH: begin
                if (timer == '0) begin
                    state_nxt = GAP;
                    timer_nxt = L_LOAD;
                end else begin
                    timer_nxt = timer - T_ONE;
                end
            end
            GAP: begin
                if (!final_gap) begin
                    timer_nxt = timer - T_ONE;
                end else if (pending != '0) begin
                    // Launch a queued edge; a same-cycle request takes its
                    // place in the queue, so the count only drops without one.
                    state_nxt = HIGH;
                    timer_nxt = H_LOAD;
                    if (!req) begin
                        pending_nxt = pending - P_ONE;
                    end
                end else if (req) begin
                    state_nxt = HIGH;
                    timer_nxt = H_LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                timer_nxt   = '0;
                pending_nxt = '0;
            end
        endcase

        if (queue_req) begin
            if (pending == PEND_MAX) begin
                drop = 1'b1;
            end else begin
                pending_nxt = pending + P_ONE;
            end
        end
    end

    // Lane state, registered output level and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            pending <= '0;
            out     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            pending <= pending_nxt;
            out     <= (state_nxt == HIGH);
            ovf     <= ovf_clr ? 1'b0 : (ovf | drop);
        end
    end

endmodule

// File: rtl/pedge_generator.sv
// Positive-edge generator: N independent lanes converting request pulses
// into clean, spaced rising edges for a downstream edge detector.
// Optional feature macro: PEDGE_GEN_DROP_CNT_EN adds a saturating 16-bit
// count of requests dropped across all lanes (drop_cnt output).
module pedge_generator
    import pedge_gen_pkg::*;
#(
    parameter int N           = 8,
    parameter int HIGH_CYCLES = 1,
    parameter int LOW_CYCLES  = 1,
    parameter int PEND_W      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          req,
    input  logic                  ovf_clr,
    output logic [N-1:0]          out,
    output logic [N-1:0]          busy,
    output logic [N-1:0]          ovf
`ifdef PEDGE_GEN_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    logic [N-1:0] drop;

    for (genvar i = 0; i < N; i++) begin : g_lane
        pedge_gen_lane #(
            .HIGH_CYCLES (HIGH_CYCLES),
            .LOW_CYCLES  (LOW_CYCLES),
            .PEND_W      (PEND_W)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .req     (req[i]),
            .ovf_clr (ovf_clr),
            .out     (out[i]),
            .busy    (busy[i]),
            .ovf     (ovf[i]),
            .drop    (drop[i])
        );
    end

`ifdef PEDGE_GEN_DROP_CNT_EN

    function automatic logic [DROP_CNT_W-1:0] popcount(input logic [N-1:0] v);
        logic [DROP_CNT_W-1:0] cnt;
        cnt = '0;
        for (int k = 0; k < N; k++) begin
            cnt = cnt + DROP_CNT_W'(v[k]);
        end
        return cnt;
    endfunction

    function automatic logic [DROP_CNT_W-1:0] sat_add(input logic [DROP_CNT_W-1:0] a,
                                                      input logic [DROP_CNT_W-1:0] b);
        logic [DROP_CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : sum[DROP_CNT_W-1:0];
    endfunction

    // Total dropped requests; ovf_clr deliberately leaves this untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else begin
            drop_cnt <= sat_add(drop_cnt, popcount(drop));
        end
    end

`else

    // Drop strobes have no consumer without the counter.
    logic drop_unused;
    assign drop_unused = ^drop;

`endif

endmodule

// File: tb/tb_pedge_generator.sv
// Bench for pedge_generator: two instances (default timing, and
// HIGH_CYCLES=3 / LOW_CYCLES=2) share stimulus and are compared every cycle
// against a timeline model (edge launch times plus pending counts), with
// directed scenarios pinned by hand-computed literals, then random traffic.
`timescale 1ns/1ps
module tb_pedge_generator;

    localparam int N        = 8;
    localparam int PEND_MAX = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         ovf_clr;
    logic [N-1:0] req;
    logic [N-1:0] out_a, busy_a, ovf_a;
    logic [N-1:0] out_b, busy_b, ovf_b;
`ifdef PEDGE_GEN_DROP_CNT_EN
    logic [15:0]  dcnt_a, dcnt_b;
`endif

    always #5 clk = ~clk;

    pedge_generator #(.N(N), .HIGH_CYCLES(1), .LOW_CYCLES(1), .PEND_W(2)) u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .ovf_clr  (ovf_clr),
        .out      (out_a),
        .busy     (busy_a),
`ifdef PEDGE_GEN_DROP_CNT_EN
        .drop_cnt (dcnt_a),
`endif
        .ovf      (ovf_a)
    );

    pedge_generator #(.N(N), .HIGH_CYCLES(3), .LOW_CYCLES(2), .PEND_W(2)) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .ovf_clr  (ovf_clr),
        .out      (out_b),
        .busy     (busy_b),
`ifdef PEDGE_GEN_DROP_CNT_EN
        .drop_cnt (dcnt_b),
`endif
        .ovf      (ovf_b)
    );

    // ---------------- timeline model ----------------
    int           cyc;
    int           launch [2][N];
    int           pend   [2][N];
    logic [N-1:0] m_ovf  [2];
    int           m_drops[2];

    int vectors     = 0;
    int ncmp        = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    function automatic int hc(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int lc(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
                launch[d][i] = -1000;
                pend[d][i]   = 0;
            end
            m_ovf[d]   = '0;
            m_drops[d] = 0;
        end
    endtask

    // Apply the inputs seen during cycle cyc and advance to cycle cyc+1.
    task automatic model_step(input logic [N-1:0] r, input logic clr);
        for (int d = 0; d < 2; d++) begin
            int ndrop;
            ndrop = 0;
            for (int i = 0; i < N; i++) begin
                int  last;
                bit  dr;
                last = launch[d][i] + hc(d) + lc(d) - 1;
                dr   = 1'b0;
                if (cyc > last) begin
                    if (r[i]) launch[d][i] = cyc + 1;
                end else if (cyc == last) begin
                    if (pend[d][i] > 0) begin
                        launch[d][i] = cyc + 1;
                        if (!r[i]) pend[d][i]--;
                    end else if (r[i]) begin
                        launch[d][i] = cyc + 1;
                    end
                end else if (r[i]) begin
                    if (pend[d][i] == PEND_MAX) dr = 1'b1;
                    else pend[d][i]++;
                end
                if (dr) ndrop++;
                m_ovf[d][i] = clr ? 1'b0 : (m_ovf[d][i] | dr);
            end
            m_drops[d] = (m_drops[d] + ndrop > 65535) ? 65535 : m_drops[d] + ndrop;
        end
        cyc++;
    endtask

    function automatic logic [N-1:0] exp_out(input int d);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            v[i] = (cyc >= launch[d][i]) && (cyc < launch[d][i] + hc(d));
        return v;
    endfunction

    function automatic logic [N-1:0] exp_busy(input int d);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            v[i] = (cyc >= launch[d][i]) && (cyc <= launch[d][i] + hc(d) + lc(d) - 1);
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (model cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("out_a",  32'(out_a),  32'(exp_out(0)));
            cmp("busy_a", 32'(busy_a), 32'(exp_busy(0)));
            cmp("ovf_a",  32'(ovf_a),  32'(m_ovf[0]));
            cmp("out_b",  32'(out_b),  32'(exp_out(1)));
            cmp("busy_b", 32'(busy_b), 32'(exp_busy(1)));
            cmp("ovf_b",  32'(ovf_b),  32'(m_ovf[1]));
`ifdef PEDGE_GEN_DROP_CNT_EN
            cmp("drop_cnt_a", 32'(dcnt_a), 32'(m_drops[0]));
            cmp("drop_cnt_b", 32'(dcnt_b), 32'(m_drops[1]));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic [N-1:0] r, input logic c);
        req     = r;
        ovf_clr = c;
        @(posedge clk);
        model_step(r, c);
        vectors++;
        #1;
    endtask

    task automatic do_reset();
        chk_en  = 1'b0;
        reset   = 1'b1;
        req     = '0;
        ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        cmp("rst_out_a",  32'(out_a),  32'h0);
        cmp("rst_busy_a", 32'(busy_a), 32'h0);
        cmp("rst_ovf_a",  32'(ovf_a),  32'h0);
        cmp("rst_out_b",  32'(out_b),  32'h0);
        chk_en = 1'b1;
    endtask

    // Reset asserted between clock edges: outputs must fall without a clock.
    task automatic mid_reset(input string tag);
        chk_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        cmp({tag, "_async_out_a"}, 32'(out_a), 32'h0);
        cmp({tag, "_async_out_b"}, 32'(out_b), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        chk_en = 1'b1;
    endtask

    logic [16:0] obs;

    initial begin
        reset   = 1'b1;
        req     = '0;
        ovf_clr = 1'b0;
        model_reset();

        // 1: single request at cycle 5
        do_reset();
        repeat (5) step('0, 1'b0);
        step(8'h01, 1'b0);
        cmp("t1_out_c6",  32'(out_a),  32'h01);
        cmp("t1_busy_c6", 32'(busy_a), 32'h01);
        step('0, 1'b0);
        cmp("t1_out_c7",  32'(out_a),  32'h00);
        cmp("t1_busy_c7", 32'(busy_a), 32'h01);
        step('0, 1'b0);
        cmp("t1_busy_c8", 32'(busy_a), 32'h00);

        // 2: slow instance, requests on lane 2 at cycles 0,1,2
        do_reset();
        obs = '0;
        for (int k = 0; k < 16; k++) begin
            step((k <= 2) ? 8'h04 : 8'h00, 1'b0);
            obs[k+1] = out_b[2];
        end
        cmp("t2_out_b2_timeline", 32'(obs), 32'h039CE);

        // 3: lane 1 held for 10 cycles -> saturation and drops
        do_reset();
        repeat (10) step(8'h02, 1'b0);
        cmp("t3_ovf_a", 32'(ovf_a), 32'h02);
        cmp("t3_ovf_b", 32'(ovf_b), 32'h02);
`ifdef PEDGE_GEN_DROP_CNT_EN
        cmp("t3_dcnt_a", 32'(dcnt_a), 32'd2);
        cmp("t3_dcnt_b", 32'(dcnt_b), 32'd5);
`endif
        step('0, 1'b1);
        cmp("t3_ovf_clr", 32'(ovf_a), 32'h00);
        repeat (15) step('0, 1'b0);

        // 4: all lanes at once
        do_reset();
        step(8'hFF, 1'b0);
        cmp("t4_out_c1", 32'(out_a), 32'hFF);
        step('0, 1'b0);
        cmp("t4_out_c2", 32'(out_a), 32'h00);
        step('0, 1'b0);
        cmp("t4_busy_c3", 32'(busy_a), 32'h00);

        // 5: reset mid-HIGH with two queued on lane 3
        do_reset();
        repeat (5) step(8'h08, 1'b0);
        cmp("t5_out_before", 32'(out_a), 32'h08);
        mid_reset("t5");
        obs = '0;
        for (int k = 0; k < 8; k++) begin
            step('0, 1'b0);
            obs[0] = obs[0] | (|out_a) | (|busy_a);
        end
        cmp("t5_quiet_after", 32'(obs), 32'h0);

        // 6: final-GAP request with one pending (lane 4); clear vs drop (lane 5)
        do_reset();
        obs = '0;
        for (int k = 0; k < 10; k++) begin
            logic [N-1:0] r;
            r = '0;
            r[4] = (k <= 2);
            r[5] = (k <= 9);
            step(r, k == 7);
            obs[k+1] = out_a[4];
            if (k == 7) begin
                cmp("t6_ovf_clear_wins", 32'(ovf_a[5]), 32'h0);
`ifdef PEDGE_GEN_DROP_CNT_EN
                cmp("t6_dcnt_counts", 32'(dcnt_a), 32'd1);
`endif
            end
        end
        cmp("t6_out_a4_timeline", 32'(obs), 32'h0002A);
        cmp("t6_ovf_set_again", 32'(ovf_a[5]), 32'h1);
        repeat (12) step('0, 1'b0);

        // Random traffic in sparse, medium and dense phases
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            logic [N-1:0] r;
            case ((k / 250) % 3)
                0:       r = N'($urandom) & N'($urandom) & N'($urandom);
                1:       r = N'($urandom);
                default: r = N'($urandom) | N'($urandom);
            endcase
            step(r, $urandom_range(0, 15) == 0);
            if (k == 2100) mid_reset("rnd");
        end
        repeat (20) step('0, 1'b0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
